// File: rtl/vram_pkg.sv
// Shared definitions for the character plotter and the display-side address mapping.
// VRAM_WRITER_CLS_EN adds the clear-screen state.
package vram_pkg;

  localparam logic [15:0] FONT_BASE   = 16'hD800;
  localparam logic [15:0] SCREEN_BASE = 16'hE000;
  localparam logic [15:0] ATTR_BASE   = 16'hF800;

  localparam logic [2:0]  LAST_ROW        = 3'd7;
  localparam logic [4:0]  ROW_LIMIT       = 5'd24;
  localparam logic [12:0] FILL_LAST       = 13'd6911;
  localparam logic [12:0] ATTR_FILL_START = 13'd6144;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_STORE = 3'd3,
`ifdef VRAM_WRITER_CLS_EN
    S_ATTRW = 3'd4,
    S_CLR   = 3'd5
`else
    S_ATTRW = 3'd4
`endif
  } state_t;

  // Spectrum interleave: y = {row, i} maps to {y[7:6], y[2:0], y[5:3], col}
  function automatic logic [12:0] pix_addr(input logic [4:0] row,
                                           input logic [4:0] col,
                                           input logic [2:0] i);
    return {row[4:3], i, row[2:0], col};
  endfunction

endpackage

// File: rtl/vram_addr_gen.sv
// Combinational address generation for font, pixel, attribute and (optionally) fill addresses.
// The fill port exists only with VRAM_WRITER_CLS_EN.
module vram_addr_gen
  import vram_pkg::*;
(
  input  logic [4:0]  row,
  input  logic [4:0]  col,
  input  logic [2:0]  i,
  input  logic [7:0]  chr,
`ifdef VRAM_WRITER_CLS_EN
  input  logic [12:0] fill,
  output logic [15:0] fill_a,
`endif
  output logic [15:0] font_a,
  output logic [15:0] pix_a,
  output logic [15:0] attr_a
);

  // Bases are ORed in; the offsets never reach the base bits.
  assign font_a = FONT_BASE   | {5'd0, chr, i};
  assign pix_a  = SCREEN_BASE | {3'd0, pix_addr(row, col, i)};
  assign attr_a = ATTR_BASE   | {6'd0, row, col};

`ifdef VRAM_WRITER_CLS_EN
  // Pixel and attribute areas are contiguous, so one linear offset covers both.
  assign fill_a = SCREEN_BASE | {3'd0, fill};
`endif

endmodule

// File: rtl/vram_writer.sv
// Character plotter: copies an 8-row glyph into Spectrum-layout VRAM, then writes its attribute.
// Optional clear-screen fill is enabled by defining VRAM_WRITER_CLS_EN.
module vram_writer
  import vram_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        START,
  input  logic        CLS,
  input  logic [7:0]  CHAR,
  input  logic [4:0]  COL,
  input  logic [4:0]  ROW,
  input  logic [7:0]  ATTR,
  output logic [15:0] A,
  input  logic [7:0]  D,
  output logic [7:0]  O,
  output logic        WE,
  output logic        BUSY,
  output logic        DONE
);

  state_t      state_r, state_s;
  logic [7:0]  char_r, attr_r;
  logic [4:0]  col_r, row_r;
  logic [2:0]  i_r, i_s;
  logic        latch_s;

  logic [7:0]  char_sel_s;
  logic [4:0]  col_sel_s, row_sel_s;
  logic [2:0]  i_sel_s;
  logic [15:0] font_a_s, pix_a_s, attr_a_s;

  logic [15:0] a_s;
  logic [7:0]  o_s;
  logic        we_s, busy_s, done_s;

`ifdef VRAM_WRITER_CLS_EN
  logic [12:0] fill_r, fill_s, fill_sel_s;
  logic [15:0] fill_a_s;
`else
  logic        unused_cls_s;
  assign unused_cls_s = CLS;
`endif

  // Address operands: live inputs while idle (request being accepted), latched copies afterwards
  always_comb begin
    if (state_r == S_IDLE) begin
      char_sel_s = CHAR;
      col_sel_s  = COL;
      row_sel_s  = ROW;
      i_sel_s    = 3'd0;
    end else begin
      char_sel_s = char_r;
      col_sel_s  = col_r;
      row_sel_s  = row_r;
      // STORE prepares the font address of the following row
      if (state_r == S_STORE) begin
        i_sel_s = i_r + 3'd1;
      end else begin
        i_sel_s = i_r;
      end
    end
`ifdef VRAM_WRITER_CLS_EN
    if (state_r == S_CLR) begin
      fill_sel_s = fill_r + 13'd1;
    end else begin
      fill_sel_s = 13'd0;
    end
`endif
  end

  vram_addr_gen u_addr (
    .row    (row_sel_s),
    .col    (col_sel_s),
    .i      (i_sel_s),
    .chr    (char_sel_s),
`ifdef VRAM_WRITER_CLS_EN
    .fill   (fill_sel_s),
    .fill_a (fill_a_s),
`endif
    .font_a (font_a_s),
    .pix_a  (pix_a_s),
    .attr_a (attr_a_s)
  );

  // Next state and the memory-port values presented during that state
  always_comb begin
    state_s = state_r;
    i_s     = i_r;
    latch_s = 1'b0;
    a_s     = A;
    o_s     = O;
    we_s    = 1'b0;
    busy_s  = 1'b1;
    done_s  = 1'b0;
`ifdef VRAM_WRITER_CLS_EN
    fill_s  = fill_r;
`endif
    case (state_r)
      S_IDLE: begin
        busy_s = 1'b0;
`ifdef VRAM_WRITER_CLS_EN
        if (CLS) begin
          state_s = S_CLR;
          latch_s = 1'b1;
          busy_s  = 1'b1;
          fill_s  = 13'd0;
          a_s     = fill_a_s;
          o_s     = 8'h00;
          we_s    = 1'b1;
        end else
`endif
        if (START) begin
          latch_s = 1'b1;
          busy_s  = 1'b1;
          i_s     = 3'd0;
          // Off-screen rows skip straight to the write-less completion cycle
          if (ROW < ROW_LIMIT) begin
            state_s = S_FETCH;
            a_s     = font_a_s;
          end else begin
            state_s = S_ATTRW;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        state_s = S_WAIT;
      end
      S_WAIT: begin
        state_s = S_STORE;
        a_s     = pix_a_s;
        o_s     = D;
        we_s    = 1'b1;
      end
      S_STORE: begin
        if (i_r == LAST_ROW) begin
          state_s = S_ATTRW;
          i_s     = 3'd0;
          a_s     = attr_a_s;
          o_s     = attr_r;
          we_s    = 1'b1;
        end else begin
          state_s = S_FETCH;
          i_s     = i_r + 3'd1;
          a_s     = font_a_s;
        end
      end
      S_ATTRW: begin
        state_s = S_IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b1;
      end
`ifdef VRAM_WRITER_CLS_EN
      S_CLR: begin
        if (fill_r == FILL_LAST) begin
          state_s = S_IDLE;
          fill_s  = 13'd0;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          fill_s = fill_sel_s;
          a_s    = fill_a_s;
          we_s   = 1'b1;
          if (fill_sel_s >= ATTR_FILL_START) begin
            o_s = attr_r;
          end else begin
            o_s = 8'h00;
          end
        end
      end
`endif
      default: begin
        state_s = S_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, latched request and registered memory-port outputs
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_r <= S_IDLE;
      i_r     <= 3'd0;
      char_r  <= 8'h00;
      col_r   <= 5'd0;
      row_r   <= 5'd0;
      attr_r  <= 8'h00;
      A       <= 16'h0000;
      O       <= 8'h00;
      WE      <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
`ifdef VRAM_WRITER_CLS_EN
      fill_r  <= 13'd0;
`endif
    end else begin
      state_r <= state_s;
      i_r     <= i_s;
      A       <= a_s;
      O       <= o_s;
      WE      <= we_s;
      BUSY    <= busy_s;
      DONE    <= done_s;
`ifdef VRAM_WRITER_CLS_EN
      fill_r  <= fill_s;
`endif
      if (latch_s) begin
        char_r <= CHAR;
        col_r  <= COL;
        row_r  <= ROW;
        attr_r <= ATTR;
      end
    end
  end

endmodule

// File: tb/tb_vram_writer.sv
// Self-checking bench for vram_writer: directed vector table, hand sequences and random
// requests compared against an arithmetic model of the screen layout.
module tb_vram_writer;

  logic        CLOCK = 1'b0;
  logic        RESET, START, CLS;
  logic [7:0]  CHAR, ATTR;
  logic [4:0]  COL, ROW;
  logic [15:0] A;
  logic [7:0]  D, O;
  logic        WE, BUSY, DONE;

  vram_writer dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .CLS(CLS),
    .CHAR(CHAR), .COL(COL), .ROW(ROW), .ATTR(ATTR),
    .A(A), .D(D), .O(O), .WE(WE), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLOCK = ~CLOCK;

  // 64 KB memory with one-clock registered read
  logic [7:0] mem [0:65535];
  logic [7:0] font_m [0:2047];
  logic [7:0] d_r;
  assign D = d_r;
  always @(posedge CLOCK) begin
    if (WE === 1'b1) mem[A] <= O;
    d_r <= mem[A];
  end

  typedef struct { int cyc; logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct {
    logic [7:0]  ch; logic [4:0] co; logic [4:0] ro; logic [7:0] at;
    logic [15:0] pix0; logic [15:0] attr_a; int nwr; int done;
  } vec_t;

  wr_t  wr_q[$];
  wr_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   busy_cnt, done_cyc, done_cnt, exp_done, exp_busy;
  vec_t vt [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference: character cell geometry computed with plain arithmetic
  task automatic build_exp(input logic [7:0] ch, input int co, input int ro, input logic [7:0] at);
    exp_q.delete();
    if (ro >= 24) begin
      exp_done = 2;
      exp_busy = 1;
    end else begin
      for (int i = 0; i < 8; i++)
        exp_q.push_back('{3 + 3*i,
                          16'(32'hE000 + (ro/8)*2048 + i*256 + (ro%8)*32 + co),
                          font_m[int'(ch)*8 + i]});
      exp_q.push_back('{25, 16'(32'hF800 + ro*32 + co), at});
      exp_done = 26;
      exp_busy = 25;
    end
  endtask

  task automatic run_op(input logic [7:0] ch, input logic [4:0] co, input logic [4:0] ro,
                        input logic [7:0] at, input logic st, input logic cl,
                        input int ncyc, input bit pulse, input int rst_at);
    wr_q.delete();
    busy_cnt = 0; done_cyc = -1; done_cnt = 0;
    @(negedge CLOCK);
    CHAR = ch; COL = co; ROW = ro; ATTR = at; START = st; CLS = cl;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge CLOCK);
      START = 1'b0; CLS = 1'b0;
      if (c == 1) begin
        CHAR = 8'($urandom); COL = 5'($urandom); ROW = 5'($urandom); ATTR = 8'($urandom);
      end
      if (pulse && c == 4)  START = 1'b1;
      if (pulse && c == 19) CLS = 1'b1;
      if (rst_at > 0 && c == rst_at) RESET = 1'b1;
      if (WE === 1'b1) wr_q.push_back('{c, A, O});
      if (BUSY === 1'b1) busy_cnt++;
      if (DONE === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (rst_at > 0 && c == rst_at + 1) begin
        RESET = 1'b0;
        chk("rst_mid_we",   32'(WE),   32'd0);
        chk("rst_mid_busy", 32'(BUSY), 32'd0);
        chk("rst_mid_done", 32'(DONE), 32'd0);
      end
    end
  endtask

  task automatic cmp_op(input string name);
    chk({name, "_nwr"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
      chk({name, "_cyc"},  32'(wr_q[k].cyc), 32'(exp_q[k].cyc));
      chk({name, "_addr"}, 32'(wr_q[k].a),   32'(exp_q[k].a));
      chk({name, "_data"}, 32'(wr_q[k].d),   32'(exp_q[k].d));
    end
    chk({name, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
    chk({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({name, "_busy"},     32'(busy_cnt), 32'(exp_busy));
  endtask

  initial begin
    logic [7:0] glyph [8];
    glyph = '{8'h00, 8'h18, 8'h24, 8'h42, 8'h7E, 8'h42, 8'h42, 8'h00};
    for (int k = 0; k < 2048; k++) font_m[k] = 8'($urandom);
    for (int k = 0; k < 8; k++) font_m[8'h41*8 + k] = glyph[k];
    for (int k = 0; k < 2048; k++) mem[16'hD800 + k] = font_m[k];

    RESET = 1'b1; START = 1'b0; CLS = 1'b0;
    CHAR = 8'h00; COL = 5'd0; ROW = 5'd0; ATTR = 8'h00;
    repeat (3) @(negedge CLOCK);
    chk("reset_a",    32'(A),    32'd0);
    chk("reset_o",    32'(O),    32'd0);
    chk("reset_we",   32'(WE),   32'd0);
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_done", 32'(DONE), 32'd0);
    RESET = 1'b0;

    // Directed cells: glyph, far corner, third boundary, off-screen rows
    vt[0] = '{8'h41, 5'd0,  5'd0,  8'h38, 16'hE000, 16'hF800, 9, 26};
    vt[1] = '{8'h41, 5'd31, 5'd23, 8'hC5, 16'hF0FF, 16'hFAFF, 9, 26};
    vt[2] = '{8'h7F, 5'd0,  5'd8,  8'h12, 16'hE800, 16'hF900, 9, 26};
    vt[3] = '{8'h20, 5'd5,  5'd24, 8'h00, 16'h0000, 16'h0000, 0, 2};
    vt[4] = '{8'hFF, 5'd9,  5'd31, 8'h55, 16'h0000, 16'h0000, 0, 2};
    for (int v = 0; v < 5; v++) begin
      run_op(vt[v].ch, vt[v].co, vt[v].ro, vt[v].at, 1'b1, 1'b0, 30, 1'b0, 0);
      build_exp(vt[v].ch, int'(vt[v].co), int'(vt[v].ro), vt[v].at);
      cmp_op("vec");
      chk("vec_nwr_tab",  32'(wr_q.size()), 32'(vt[v].nwr));
      chk("vec_done_tab", 32'(done_cyc),    32'(vt[v].done));
      if (wr_q.size() == 9) begin
        chk("vec_pix0", 32'(wr_q[0].a), 32'(vt[v].pix0));
        chk("vec_attr", 32'(wr_q[8].a), 32'(vt[v].attr_a));
      end
    end
    chk("corner_last_pix", 32'(exp_q.size()), 32'd0);

    // Requests while busy are dropped
    run_op(8'h41, 5'd3, 5'd5, 8'h0F, 1'b1, 1'b0, 32, 1'b1, 0);
    build_exp(8'h41, 3, 5, 8'h0F);
    cmp_op("busy_pulse");

    // Reset mid-glyph, then a full sequence
    run_op(8'h41, 5'd2, 5'd2, 8'h44, 1'b1, 1'b0, 20, 1'b0, 10);
    chk("rst_nwr",  32'(wr_q.size()), 32'd3);
    chk("rst_done", 32'(done_cnt),    32'd0);
    chk("rst_busy", 32'(busy_cnt),    32'd10);
    run_op(8'h41, 5'd2, 5'd2, 8'h44, 1'b1, 1'b0, 30, 1'b0, 0);
    build_exp(8'h41, 2, 2, 8'h44);
    cmp_op("after_rst");

`ifdef VRAM_WRITER_CLS_EN
    begin
      int bad_a, bad_d;
      bad_a = -1; bad_d = -1;
      run_op(8'h00, 5'd0, 5'd0, 8'h07, 1'b0, 1'b1, 6920, 1'b0, 0);
      chk("cls_nwr", 32'(wr_q.size()), 32'd6912);
      for (int k = 0; k < wr_q.size(); k++) begin
        if (bad_a < 0 && wr_q[k].a !== 16'(32'hE000 + k)) bad_a = k;
        if (bad_d < 0 && wr_q[k].d !== ((k < 6144) ? 8'h00 : 8'h07)) bad_d = k;
      end
      chk("cls_addr_seq", 32'(bad_a), 32'hFFFF_FFFF);
      chk("cls_data_seq", 32'(bad_d), 32'hFFFF_FFFF);
      chk("cls_busy",     32'(busy_cnt), 32'd6912);
      chk("cls_done_cyc", 32'(done_cyc), 32'd6913);
    end
`else
    run_op(8'h41, 5'd0, 5'd0, 8'h07, 1'b0, 1'b1, 10, 1'b0, 0);
    chk("cls_off_nwr",  32'(wr_q.size()), 32'd0);
    chk("cls_off_busy", 32'(busy_cnt),    32'd0);
    chk("cls_off_done", 32'(done_cnt),    32'd0);
    run_op(8'h41, 5'd1, 5'd1, 8'h07, 1'b1, 1'b1, 30, 1'b0, 0);
    build_exp(8'h41, 1, 1, 8'h07);
    cmp_op("cls_start");
`endif

    // Random requests, including some off-screen rows
    for (int n = 0; n < 8; n++) begin
      logic [7:0] ch, at;
      logic [4:0] co, ro;
      ch = 8'($urandom); at = 8'($urandom);
      co = 5'($urandom); ro = 5'($urandom_range(0, 27));
      run_op(ch, co, ro, at, 1'b1, 1'b0, 30, 1'b0, 0);
      build_exp(ch, int'(co), int'(ro), at);
      cmp_op("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
